// File: rtl/regfile_pkg.sv
// Shared constants, address type and width helper for the register file
// with its pending-write scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] addr_t;

    // Width of a counter that can hold any popcount of an n-bit vector (n a power of two).
    function automatic int pop_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback port bundle of the register file: operand reads,
// writeback, reservation and flush.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);
    localparam int CW = pop_width(NREG);

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ok;
    logic                flush;
    logic [CW-1:0]       pend_cnt;

    modport master (
        output rs_addr, we, wa, wd, rsv_en, rsv_addr, flush,
        input  rs_data, rs_busy, rsv_ok, pend_cnt
    );

    modport slave (
        input  rs_addr, we, wa, wd, rsv_en, rsv_addr, flush,
        output rs_data, rs_busy, rsv_ok, pend_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding long-latency
// write, accepts reservations and keeps a running count of busy entries.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = $clog2(NREG),
    localparam int CW   = pop_width(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic            rsv_ok,
    output logic [CW-1:0]   pend_cnt
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic [CW-1:0]   pend_reg;
    logic [CW-1:0]   pend_next;
    logic            wr_valid;
    logic            release_hit;

    assign wr_valid = we && (wa != '0);

    // Gated by rst_n so nothing is reported accepted while reset is held.
    assign rsv_ok = rst_n && rsv_en && (rsv_addr != '0) && !busy_reg[rsv_addr] && !flush;

    // A release only counts if it actually drops a busy bit that is not re-set this cycle.
    assign release_hit = wr_valid && busy_reg[wa] && !(rsv_ok && (rsv_addr == wa));

    always_comb begin
        busy_next = busy_reg;
        pend_next = pend_reg;
        if (flush) begin
            busy_next = '0;
            pend_next = '0;
        end else begin
            if (wr_valid) begin
                busy_next[wa] = 1'b0;
            end
            if (rsv_ok) begin
                busy_next[rsv_addr] = 1'b1;
            end
            pend_next = pend_reg + CW'(rsv_ok) - CW'(release_hit);
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
            pend_reg <= '0;
        end else begin
            busy_reg <= busy_next;
            pend_reg <= pend_next;
        end
    end

    assign busy     = busy_reg;
    assign pend_cnt = pend_reg;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with zero register, optional writeback-to-read
// bypass and an integrated pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);

    localparam int   AW  = $clog2(NREG);
    localparam logic BYP = (BYPASS != 0);

    logic [XLEN-1:0] mem_reg [NREG];
    logic [NREG-1:0] busy_vec;

    // Entry 0 is reset to zero and never written, so it always reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (bus.we && (bus.wa != '0)) begin
            mem_reg[bus.wa] <= bus.wd;
        end
    end

    regfile_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .we       (bus.we),
        .wa       (bus.wa),
        .flush    (bus.flush),
        .busy     (busy_vec),
        .rsv_ok   (bus.rsv_ok),
        .pend_cnt (bus.pend_cnt)
    );

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;

        assign addr = bus.rs_addr[gi*AW +: AW];
        // A same-cycle writeback both supplies the data and hides the busy bit it is about to clear.
        assign hit  = BYP && rst_n && bus.we && (bus.wa == addr);

        assign bus.rs_data[gi*XLEN +: XLEN] = (addr == '0) ? '0 :
                                              (hit ? bus.wd : mem_reg[addr]);
        assign bus.rs_busy[gi] = (addr != '0) && !hit && busy_vec[addr];
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with configurable width, depth and read-port count, same-cycle write-to-read bypass, and an integrated scoreboard of pending writes. Sits in the decode stage of the RISC pipeline: decode reads operands and checks hazards here, and reserves the destination of long-latency instructions. Writeback writes and releases the reservation. Register 0 is hardwired to zero and never becomes busy.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; a power of two, at least 2. AW = $clog2(NREG).
- NRD, 2, number of independent read ports, at least 1.
- BYPASS, 1, when 1, same-cycle writeback data is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs_addr  in  NRD*AW  packed read addresses; port k uses slice [k*AW +: AW].
- rs_data  out  NRD*XLEN  packed read data, combinational.
- rs_busy  out  NRD  per-port flag: the addressed register has a pending write.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- rsv_en  in  1  reserve request for rsv_addr.
- rsv_addr  in  AW  register to reserve.
- rsv_ok  out  1  reservation accepted this cycle, combinational.
- flush  in  1  clear all reservations; register contents are kept.
- pend_cnt  out  AW+1  number of currently busy registers, registered.

## Operation
- Storage: NREG x XLEN array plus a NREG-bit busy vector. Entry 0 always reads as 0, and writes to it are ignored.
- Write: when we=1 and wa!=0, mem[wa] <= wd at the edge. The write also clears busy[wa].
- Read port k:
  - If rs_addr_k==0, rs_data_k=0 and rs_busy_k=0.
  - Otherwise, if BYPASS=1, we=1 and wa==rs_addr_k, then rs_data_k=wd and rs_busy_k=0.
  - Otherwise, rs_data_k=mem[rs_addr_k] and rs_busy_k=busy[rs_addr_k].
- Reserve:
  - rsv_ok = rsv_en & (rsv_addr!=0) & ~busy[rsv_addr] & ~flush. This refuses WAW on an already-busy register.
  - An accepted reservation sets busy[rsv_addr] at the edge.
- Simultaneous write and accepted reserve on the same register: the reserve wins, so busy stays 1. This does not happen if the register was busy, because rsv_ok would be 0.
- flush=1 clears every busy bit and sets pend_cnt to 0. It overrides reserve and write-release in that cycle, but the data write still happens.
- pend_cnt update each edge, in priority order:
  - flush: set to 0.
  - Otherwise: +1 for an accepted reserve, and -1 for a write whose wa!=0 has busy[wa]=1 and is not reserved again in the same cycle.
  - Both events in one cycle: net change 0.
  - Never exceeds NREG-1.
  - pend_cnt always equals popcount(busy).

## Timing
- Reset (rst_n=0, asynchronous) clears all mem entries, all busy bits and pend_cnt to 0. While reset is held, rs_data=0, rs_busy=0 and rsv_ok=0 (assuming rs_addr and rsv_addr are valid).
- Reset asserted mid-operation drops pending reservations immediately, with no edge required.
- Read latency is 0 cycles (combinational from address).
- A write becomes visible through mem on the cycle after the edge. With BYPASS=1 it is also visible in the same cycle; with BYPASS=0 it is not.
- A reservation is visible on rs_busy on the cycle after acceptance.
- Every port is independent, and all NRD ports may address the same register.

## Structure
- Package regfile_pkg holds:
  - the default XLEN and NREG constants;
  - an addr_t typedef for an AW-bit address;
  - a popcount-width helper function.
- Sub-module regfile_scoreboard holds the busy vector, rsv_ok, the release logic and pend_cnt. Inputs: rsv_en, rsv_addr, we, wa, flush.
- The top level holds the storage array, the read muxes and the bypass.

## Test plan
- Reset then read: with NRD=2, read r5 and r0 -> rs_data=0, rs_busy=00, pend_cnt=0.
- Write then read: we=1, wa=3, wd=0xDEADBEEF, rs_addr0=3.
  - BYPASS=1: rs_data0=0xDEADBEEF in the same cycle.
  - BYPASS=0: 0 in that cycle, 0xDEADBEEF in the next.
- Write to x0: we=1, wa=0, wd=0x1234 -> r0 still reads 0; a reserve of r0 gives rsv_ok=0.
- Reserve and release: reserve r7 -> rsv_ok=1, and next cycle rs_busy=1 and pend_cnt=1.
  - Reserving r7 again -> rsv_ok=0.
  - Writeback to r7 -> busy cleared and pend_cnt=0 next cycle.
  - With BYPASS=1, rs_busy=0 already in the writeback cycle.
- Simultaneous events: r4 is busy; in one cycle, write r4 and reserve r9 -> busy r4=0, r9=1, pend_cnt unchanged at 1. Then flush together with a reserve of r2 -> pend_cnt=0, rsv_ok=0.
- Async reset mid-run: reserve r1, r2 and r3 and write several registers, then pulse rst_n low between edges -> pend_cnt=0 and all reads 0 immediately, without waiting for a clock edge.
